// File: rtl/fp_norm_round.sv
// -----------------------------------------------------------------------------
// fp_norm_round
//
// Normalise-and-round stage that sits directly behind a single-precision
// add/subtract datapath. It receives the un-normalised raw result (sign,
// biased exponent, {carry, hidden, fraction} mantissa and guard/round/sticky),
// normalises it one bit position per clock, rounds to nearest-even and returns
// a packed IEEE-754 word plus zero/overflow/underflow flags.
//
// One operation is in flight at a time; the stage is idle-accept, then busy
// until the result has been handed off downstream.
//
// Ports
//   clk        : clock, rising edge
//   RST        : synchronous reset, active high
//   EN         : clock enable; 0 freezes every register (stall)
//   in_valid   : upstream raw result valid
//   in_ready   : stage can accept (high only while idle)
//   in_sign    : raw result sign
//   in_exp     : biased exponent before normalisation
//   in_mant    : {carry, hidden, fraction}, MANT_W+2 bits
//   in_grs     : {guard, round, sticky} below the fraction LSB
//   out_valid  : out_result/flags valid; held until out_ready
//   out_ready  : downstream accepts the result
//   out_result : packed {sign, exponent, fraction}
//   out_zero   : exact zero from cancellation (always +0)
//   out_ovf    : exponent overflow, result is signed infinity
//   out_unf    : exponent underflow, result flushed to zero
// -----------------------------------------------------------------------------
module fp_norm_round #(
   parameter int unsigned EXP_W      = 8,
   parameter int unsigned MANT_W     = 23,
   parameter bit          FLUSH_SIGN = 1'b1
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic                  EN,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_sign,
   input  logic [EXP_W-1:0]      in_exp,
   input  logic [MANT_W+1:0]     in_mant,
   input  logic [2:0]            in_grs,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [EXP_W+MANT_W:0] out_result,
   output logic                  out_zero,
   output logic                  out_ovf,
   output logic                  out_unf
);

   localparam int unsigned RES_W   = EXP_W + MANT_W + 1;
   // Enough left shifts to walk a 1 from the round position up to the hidden
   // bit; anything still unnormalised after that is sticky-only residue.
   localparam int unsigned MAX_LSH = MANT_W + 3;
   localparam int unsigned SH_W    = $clog2(MAX_LSH + 1);

   localparam logic [EXP_W-1:0]  EXP_MAX   = '1;
   localparam logic [EXP_W-1:0]  EXP_ZERO  = '0;
   localparam logic [EXP_W-1:0]  EXP_ONE   = EXP_W'(1);
   localparam logic [MANT_W-1:0] FRAC_ZERO = '0;
   localparam logic [MANT_W+1:0] MANT_ONE  = {2'b01, FRAC_ZERO};
   localparam logic [SH_W-1:0]   LSH_LAST  = SH_W'(MAX_LSH);
   localparam logic [SH_W-1:0]   LSH_ONE   = SH_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_e;

   // ---------------------------------------------------------------------------
   // State and working registers
   // ---------------------------------------------------------------------------
   state_e            state_q, state_d;
   logic              sign_q,  sign_d;
   logic [EXP_W-1:0]  exp_q,   exp_d;
   logic [MANT_W+1:0] mant_q,  mant_d;
   logic              g_q,     g_d;
   logic              r_q,     r_d;
   logic              s_q,     s_d;
   logic [SH_W-1:0]   lsh_q,   lsh_d;
   logic [RES_W-1:0]  res_q,   res_d;
   logic              zero_q,  zero_d;
   logic              ovf_q,   ovf_d;
   logic              unf_q,   unf_d;

   // ---------------------------------------------------------------------------
   // Datapath helpers
   // ---------------------------------------------------------------------------
   logic              flush_sign;
   logic              is_zero;
   logic [EXP_W-1:0]  exp_dec;
   logic              rnd_inc;
   logic [MANT_W+1:0] rnd_sum;
   logic              rnd_carry;
   logic [EXP_W:0]    exp_rnd;
   logic              rnd_ovf;
   logic [RES_W-1:0]  inf_word;
   logic [RES_W-1:0]  flush_word;

   assign flush_sign = FLUSH_SIGN ? sign_q : 1'b0;
   assign is_zero    = (mant_q == '0) && !(g_q | r_q | s_q);
   assign exp_dec    = exp_q - EXP_ONE;

   // Round to nearest, ties to even: bump only above half-way, or exactly at
   // half-way when the kept LSB is odd.
   assign rnd_inc    = g_q & (r_q | s_q | mant_q[0]);
   assign rnd_sum    = {1'b0, mant_q[MANT_W:0]} + {{(MANT_W+1){1'b0}}, rnd_inc};
   assign rnd_carry  = rnd_sum[MANT_W+1];

   // One spare bit so a carry out of an already-maximal exponent cannot wrap.
   assign exp_rnd    = {1'b0, exp_q} + {{EXP_W{1'b0}}, rnd_carry};
   assign rnd_ovf    = (exp_rnd >= {1'b0, EXP_MAX});

   assign inf_word   = {sign_q, EXP_MAX, FRAC_ZERO};
   assign flush_word = {flush_sign, EXP_ZERO, FRAC_ZERO};

   // ---------------------------------------------------------------------------
   // Next-state / datapath logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets its hold value first, so no path through the
   // case can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      mant_d  = mant_q;
      g_d     = g_q;
      r_d     = r_q;
      s_d     = s_q;
      lsh_d   = lsh_q;
      res_d   = res_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d  = in_sign;
               exp_d   = in_exp;
               mant_d  = in_mant;
               {g_d, r_d, s_d} = in_grs;
               lsh_d   = '0;
               res_d   = '0;
               zero_d  = 1'b0;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               state_d = NORM;
            end
         end

         NORM: begin
            if (is_zero) begin
               // Exact cancellation always yields +0.
               res_d   = '0;
               zero_d  = 1'b1;
               state_d = DONE;
            end else if (exp_q == EXP_MAX) begin
               // Infinite operand: no normalisation or rounding applies.
               res_d   = inf_word;
               ovf_d   = 1'b1;
               state_d = DONE;
            end else if (exp_q == EXP_ZERO) begin
               res_d   = flush_word;
               unf_d   = 1'b1;
               state_d = DONE;
            end else if (mant_q[MANT_W+1]) begin
               // Carry out of the adder: one right shift folds the lost LSB
               // into guard and squeezes old guard/round down.
               mant_d  = {1'b0, mant_q[MANT_W+1:1]};
               g_d     = mant_q[0];
               r_d     = g_q;
               s_d     = r_q | s_q;
               exp_d   = exp_q + EXP_ONE;
               state_d = ROUND;
            end else if (mant_q[MANT_W]) begin
               state_d = ROUND;
            end else if (lsh_q == LSH_LAST) begin
               // Only sticky is left below the working window: the value is
               // too small to ever normalise, treat it as underflow.
               res_d   = flush_word;
               unf_d   = 1'b1;
               state_d = DONE;
            end else begin
               // Left shift pulls guard into the mantissa LSB and round into
               // guard; sticky stays put since it is an OR of lost bits.
               mant_d  = {mant_q[MANT_W:0], g_q};
               g_d     = r_q;
               r_d     = 1'b0;
               exp_d   = exp_dec;
               lsh_d   = lsh_q + LSH_ONE;
               if (exp_dec == EXP_ZERO) begin
                  res_d   = flush_word;
                  unf_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end

         ROUND: begin
            exp_d  = exp_rnd[EXP_W-1:0];
            mant_d = rnd_carry ? MANT_ONE : rnd_sum;
            if (rnd_ovf) begin
               res_d = inf_word;
               ovf_d = 1'b1;
            end else begin
               res_d = {sign_q, exp_rnd[EXP_W-1:0],
                        rnd_carry ? FRAC_ZERO : rnd_sum[MANT_W-1:0]};
            end
            state_d = DONE;
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (RST) begin
         // NOTE: the working registers are plain flops, not a memory array, so
         // they are reset along with the FSM to keep the outputs defined.
         state_q <= IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         mant_q  <= '0;
         g_q     <= 1'b0;
         r_q     <= 1'b0;
         s_q     <= 1'b0;
         lsh_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (EN) begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         mant_q  <= mant_d;
         g_q     <= g_d;
         r_q     <= r_d;
         s_q     <= s_d;
         lsh_q   <= lsh_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign out_result = res_q;
   assign out_zero   = zero_q;
   assign out_ovf    = ovf_q;
   assign out_unf    = unf_q;

endmodule
